// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store initiator for RAM port B (optional LSU_MISALIGN_SPLIT_EN splits word-crossing accesses).
// Response at N+1 (store/error) or N+2 (load), +1 when split; ram_NOTready blocks acceptance and stretches every RAM-facing state.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] ram_addrB,
  output logic [3:0]  ram_web,
  output logic [31:0] ram_dinB,
  input  logic [31:0] ram_doutB,
  input  logic        ram_readValidB,
  input  logic        ram_NOTready
);
  localparam logic [1:0] MEM_DISABLE   = 2'b00;
  localparam logic [1:0] MEM_READ_SEXT = 2'b01;
  localparam logic [1:0] MEM_WRITE     = 2'b11;

  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, WR_HI} state_t;
  state_t state;

  logic [1:0]  opR, sizeR, offR;
  logic        splitR;
  logic [31:0] wordAddrR, loWordR, addrHold, dinHold, nextWordAddr;
  logic [3:0]  hiWebR, mask;
  logic [1:0]  off;
  logic [7:0]  webWide;
  logic [63:0] dinWide;
  logic        accept, isStore, reservedSize, reqErr, split, doAccess, rdCapture;

  // Shift a (possibly two-word) read so the addressed byte lands in lane 0, then extend.
  function automatic logic [31:0] extend(input logic [63:0] merged, input logic [1:0] sh,
                                         input logic [1:0] size, input logic [1:0] op);
    logic [31:0] d;
    d = 32'(merged >> {sh, 3'b000});
    case (size)
      2'b00:   extend = (op == MEM_READ_SEXT) ? {{24{d[7]}}, d[7:0]} : {24'b0, d[7:0]};
      2'b01:   extend = (op == MEM_READ_SEXT) ? {{16{d[15]}}, d[15:0]} : {16'b0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign req_ready    = (state == IDLE) && !ram_NOTready && !reset;
  assign accept       = req_valid && req_ready;
  assign off          = req_addr[1:0];
  assign isStore      = (req_op == MEM_WRITE);
  assign reservedSize = (req_size == 2'b11);

  always_comb begin
    case (req_size)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

  // Upper halves of these are the second-word enables/data of a word-crossing store.
  assign webWide = {4'b0000, mask} << off;
  assign dinWide = {32'b0, req_wdata} << {off, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
  assign reqErr = reservedSize;
  assign split  = !reservedSize && (webWide[7:4] != 4'b0000);
`else
  assign reqErr = reservedSize || (req_size == 2'b01 && off[0]) ||
                  (req_size == 2'b10 && off != 2'b00);
  assign split  = 1'b0;
`endif

  assign doAccess     = accept && (req_op != MEM_DISABLE) && !reqErr;
  assign rdCapture    = ram_readValidB && !ram_NOTready;
  assign nextWordAddr = wordAddrR + 32'd4;

  always_comb begin
    ram_addrB = addrHold;
    ram_dinB  = dinHold;
    ram_web   = 4'b0000;
    if (doAccess) begin
      ram_addrB = {req_addr[31:2], 2'b00};
      if (isStore) begin
        ram_web  = webWide[3:0];
        ram_dinB = dinWide[31:0];
      end
    end else if (state == RD_LO && splitR && rdCapture) begin
      ram_addrB = nextWordAddr;
    end else if (state == WR_HI && !reset) begin
      ram_web = hiWebR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'b0;
      resp_err   <= 1'b0;
      addrHold   <= 32'b0;
      dinHold    <= 32'b0;
      opR        <= 2'b00;
      sizeR      <= 2'b00;
      offR       <= 2'b00;
      splitR     <= 1'b0;
      wordAddrR  <= 32'b0;
      loWordR    <= 32'b0;
      hiWebR     <= 4'b0000;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && req_op != MEM_DISABLE) begin
            opR       <= req_op;
            sizeR     <= req_size;
            offR      <= off;
            splitR    <= split;
            wordAddrR <= {req_addr[31:2], 2'b00};
            hiWebR    <= webWide[7:4];
            if (reqErr) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'b0;
            end else if (!isStore) begin
              addrHold <= {req_addr[31:2], 2'b00};
              state    <= RD_LO;
            end else if (split) begin
              addrHold <= {req_addr[31:2], 2'b00} + 32'd4;
              dinHold  <= dinWide[63:32];
              state    <= WR_HI;
            end else begin
              addrHold   <= {req_addr[31:2], 2'b00};
              dinHold    <= dinWide[31:0];
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= 32'b0;
            end
          end
        end
        RD_LO: begin
          if (rdCapture) begin
            if (splitR) begin
              loWordR  <= ram_doutB;
              addrHold <= nextWordAddr;
              state    <= RD_HI;
            end else begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= extend({32'b0, ram_doutB}, offR, sizeR, opR);
              state      <= IDLE;
            end
          end
        end
        RD_HI: begin
          if (rdCapture) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= extend({ram_doutB, loWordR}, offR, sizeR, opR);
            state      <= IDLE;
          end
        end
        WR_HI: begin
          if (!ram_NOTready) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= 32'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural port-B RAM, response scoreboard, one task per scenario.
// Build with or without LSU_MISALIGN_SPLIT_EN; misaligned expectations follow the same macro.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op, req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] ram_addrB, ram_dinB, ram_doutB;
  logic [3:0]  ram_web;
  logic        ram_readValidB, ram_NOTready;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_addrB(ram_addrB), .ram_web(ram_web), .ram_dinB(ram_dinB),
    .ram_doutB(ram_doutB), .ram_readValidB(ram_readValidB), .ram_NOTready(ram_NOTready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read, readValid = registered (web==0); everything holds while busy.
  logic [31:0] mem [0:1023];
  logic        pokeEn = 1'b0;
  logic [9:0]  pokeIdx;
  logic [31:0] pokeData;
  always @(posedge clk) begin
    if (pokeEn) mem[pokeIdx] <= pokeData;
    if (!ram_NOTready) begin
      for (int i = 0; i < 4; i++)
        if (ram_web[i]) mem[ram_addrB[11:2]][8*i +: 8] <= ram_dinB[8*i +: 8];
      ram_doutB      <= mem[ram_addrB[11:2]];
      ram_readValidB <= (ram_web == 4'b0000);
    end
  end

  typedef struct { logic [31:0] rdata; logic err; int due; } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp got rdata=%h err=%b at cyc %0d, want no response", resp_rdata, resp_err, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (resp_rdata !== e.rdata || resp_err !== e.err || cyc !== e.due) begin
          bad++;
          $display("FAIL resp got rdata=%h err=%b cyc=%0d, want rdata=%h err=%b cyc=%0d",
                   resp_rdata, resp_err, cyc, e.rdata, e.err, e.due);
        end
      end
    end
  end

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    pokeEn = 1'b1; pokeIdx = addr[11:2]; pokeData = data;
    @(posedge clk); #1;
    pokeEn = 1'b0;
  endtask

  task automatic expect_resp(input logic [31:0] rdata, input logic err, input int lat);
    exp_t e;
    e.rdata = rdata; e.err = err; e.due = cyc + lat;
    sbq.push_back(e);
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_op = op; req_size = size; req_addr = addr; req_wdata = wdata;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (sbq.size() == 0) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; ram_NOTready = 1'b0;
    req_op = 2'b00; req_size = 2'b00; req_addr = 32'b0; req_wdata = 32'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    total++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp got %h/%b want 0/0", resp_rdata, resp_err); end
    total++; if (ram_web !== 4'h0 || ram_addrB !== 32'h0 || ram_dinB !== 32'h0) begin bad++; $display("FAIL reset_ram got web=%b addr=%h din=%h want 0", ram_web, ram_addrB, ram_dinB); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", req_ready); end
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got %b want 1", req_ready); end
  endtask

  task automatic test_load_byte();
    bit ok;
    poke(32'h100, 32'h80FF_1234);
    @(posedge clk); #1;
    drive_req(2'b01, 2'b00, 32'h103, 32'h0);
    expect_resp(32'hFFFF_FF80, 1'b0, 2);
    @(negedge clk);
    total++; if (ram_web !== 4'b0000 || ram_addrB !== 32'h100) begin bad++; $display("FAIL lb_ram got web=%b addr=%h want 0000/00000100", ram_web, ram_addrB); end
    @(posedge clk); #1; req_valid = 1'b0;
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL lb_timeout got %0d pending want 0", sbq.size()); end
  endtask

  task automatic test_load_half();
    bit ok;
    poke(32'h200, 32'hBEEF_0000);
    @(posedge clk); #1;
    drive_req(2'b10, 2'b01, 32'h202, 32'h0);
    expect_resp(32'h0000_BEEF, 1'b0, 2);
    @(posedge clk); #1; req_valid = 1'b0;
    drain(ok);
    @(posedge clk); #1;
    drive_req(2'b01, 2'b01, 32'h202, 32'h0);
    expect_resp(32'hFFFF_BEEF, 1'b0, 2);
    @(posedge clk); #1; req_valid = 1'b0;
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL lh_timeout got %0d pending want 0", sbq.size()); end
    total++; if (resp_valid !== 1'b0 || resp_rdata !== 32'hFFFF_BEEF) begin bad++; $display("FAIL lh_hold got %b/%h want 0/ffffbeef", resp_valid, resp_rdata); end
  endtask

  task automatic test_store_byte();
    bit ok;
    poke(32'h300, 32'h1122_3344);
    @(posedge clk); #1;
    drive_req(2'b11, 2'b00, 32'h301, 32'h1234_56AB);
    expect_resp(32'h0, 1'b0, 1);
    @(negedge clk);
    total++; if (ram_web !== 4'b0010 || ram_addrB !== 32'h300) begin bad++; $display("FAIL sb_web got %b/%h want 0010/00000300", ram_web, ram_addrB); end
    total++; if (ram_dinB[15:8] !== 8'hAB) begin bad++; $display("FAIL sb_din got %h want ab", ram_dinB[15:8]); end
    @(posedge clk); #1; req_valid = 1'b0;
    drain(ok);
    total++; if (!ok || mem[32'h300 >> 2] !== 32'h1122_AB44) begin bad++; $display("FAIL sb_mem got %h want 1122ab44", mem[32'h300 >> 2]); end
  endtask

  task automatic test_misaligned();
    bit ok;
    poke(32'h400, 32'h3322_1100);
    poke(32'h404, 32'h7766_5544);
    poke(32'h600, 32'h0);
    poke(32'h604, 32'h0);
    @(posedge clk); #1;
    drive_req(2'b01, 2'b10, 32'h402, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
    expect_resp(32'h5544_3322, 1'b0, 3);
`else
    expect_resp(32'h0, 1'b1, 1);
`endif
    @(negedge clk);
    total++; if (ram_web !== 4'b0000) begin bad++; $display("FAIL mw_web got %b want 0000", ram_web); end
    @(posedge clk); #1; req_valid = 1'b0;
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL mw_timeout got %0d pending want 0", sbq.size()); end
    @(posedge clk); #1;
    drive_req(2'b11, 2'b01, 32'h603, 32'h0000_1234);
`ifdef LSU_MISALIGN_SPLIT_EN
    expect_resp(32'h0, 1'b0, 2);
    @(negedge clk);
    total++; if (ram_web !== 4'b1000 || ram_dinB[31:24] !== 8'h34) begin bad++; $display("FAIL ms_lo got %b/%h want 1000/34", ram_web, ram_dinB[31:24]); end
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    total++; if (ram_web !== 4'b0001 || ram_addrB !== 32'h604 || ram_dinB[7:0] !== 8'h12) begin bad++; $display("FAIL ms_hi got %b/%h/%h want 0001/00000604/12", ram_web, ram_addrB, ram_dinB[7:0]); end
    drain(ok);
    total++; if (!ok || mem[32'h600 >> 2] !== 32'h3400_0000 || mem[32'h604 >> 2] !== 32'h0000_0012) begin bad++; $display("FAIL ms_mem got %h %h want 34000000 00000012", mem[32'h600 >> 2], mem[32'h604 >> 2]); end
`else
    expect_resp(32'h0, 1'b1, 1);
    @(negedge clk);
    total++; if (ram_web !== 4'b0000) begin bad++; $display("FAIL ms_web got %b want 0000", ram_web); end
    @(posedge clk); #1; req_valid = 1'b0;
    drain(ok);
    total++; if (!ok || mem[32'h600 >> 2] !== 32'h0 || mem[32'h604 >> 2] !== 32'h0) begin bad++; $display("FAIL ms_mem got %h %h want 0 0", mem[32'h600 >> 2], mem[32'h604 >> 2]); end
`endif
  endtask

  task automatic test_store_reset();
    bit ok;
    poke(32'h500, 32'h0102_0304);
    poke(32'h504, 32'h0506_0708);
    @(posedge clk); #1;
    drive_req(2'b11, 2'b10, 32'h503, 32'hDDCC_BBAA);
`ifdef LSU_MISALIGN_SPLIT_EN
    @(negedge clk);
    total++; if (ram_web !== 4'b1000 || ram_dinB[31:24] !== 8'hAA) begin bad++; $display("FAIL sr_lo got %b/%h want 1000/aa", ram_web, ram_dinB[31:24]); end
    @(posedge clk); #1; req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    total++; if (ram_web !== 4'b0000) begin bad++; $display("FAIL sr_hi_web got %b want 0000", ram_web); end
    @(posedge clk); #1; reset = 1'b0;
    drain(ok);
    total++; if (mem[32'h500 >> 2] !== 32'hAA02_0304 || mem[32'h504 >> 2] !== 32'h0506_0708) begin bad++; $display("FAIL sr_mem got %h %h want aa020304 05060708", mem[32'h500 >> 2], mem[32'h504 >> 2]); end
`else
    expect_resp(32'h0, 1'b1, 1);
    @(negedge clk);
    total++; if (ram_web !== 4'b0000) begin bad++; $display("FAIL sr_web got %b want 0000", ram_web); end
    @(posedge clk); #1; req_valid = 1'b0;
    drain(ok);
    total++; if (!ok || mem[32'h500 >> 2] !== 32'h0102_0304 || mem[32'h504 >> 2] !== 32'h0506_0708) begin bad++; $display("FAIL sr_mem got %h %h want 01020304 05060708", mem[32'h500 >> 2], mem[32'h504 >> 2]); end
`endif
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL sr_idle got ready=%b want 1", req_ready); end
  endtask

  task automatic test_notready();
    bit ok;
    poke(32'h700, 32'hCAFE_F00D);
    @(posedge clk); #1;
    drive_req(2'b10, 2'b10, 32'h700, 32'h0);
    expect_resp(32'hCAFE_F00D, 1'b0, 4);
    @(posedge clk); #1; req_valid = 1'b0; ram_NOTready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (req_ready !== 1'b0 || ram_addrB !== 32'h700 || ram_web !== 4'b0000) begin bad++; $display("FAIL nr_hold%0d got ready=%b addr=%h web=%b want 0/00000700/0000", i, req_ready, ram_addrB, ram_web); end
      @(posedge clk); #1;
    end
    ram_NOTready = 1'b0;
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL nr_timeout got %0d pending want 0", sbq.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    poke(32'h310, 32'h0);
    @(posedge clk); #1;
    drive_req(2'b11, 2'b00, 32'h310, 32'h0000_0011);
    expect_resp(32'h0, 1'b0, 1);
    @(posedge clk); #1;
    drive_req(2'b11, 2'b01, 32'h312, 32'h0000_2233);
    expect_resp(32'h0, 1'b0, 1);
    @(negedge clk);
    total++; if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got valid=%b ready=%b want 1/1", resp_valid, req_ready); end
    total++; if (ram_web !== 4'b1100 || ram_dinB !== 32'h2233_0000) begin bad++; $display("FAIL b2b_web got %b/%h want 1100/22330000", ram_web, ram_dinB); end
    @(posedge clk); #1;
    drive_req(2'b00, 2'b10, 32'h310, 32'hFFFF_FFFF);
    @(negedge clk);
    total++; if (ram_web !== 4'b0000) begin bad++; $display("FAIL disable_web got %b want 0000", ram_web); end
    @(posedge clk); #1;
    drive_req(2'b11, 2'b11, 32'h310, 32'hFFFF_FFFF);
    expect_resp(32'h0, 1'b1, 1);
    @(negedge clk);
    total++; if (ram_web !== 4'b0000) begin bad++; $display("FAIL rsv_web got %b want 0000", ram_web); end
    @(posedge clk); #1; req_valid = 1'b0;
    drain(ok);
    total++; if (!ok || mem[32'h310 >> 2] !== 32'h2233_0011) begin bad++; $display("FAIL b2b_mem got %h want 22330011", mem[32'h310 >> 2]); end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_load_half();
    test_store_byte();
    test_misaligned();
    test_store_reset();
    test_notready();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator for the data port (port B) of the dual-port instruction/data RAM. Accepts one load or store at a time from the memory stage, drives the RAM's byte-enable write/read interface, then returns sign- or zero-extended load data or a store acknowledge. It sits between the MEM pipeline stage and the RAM port-B pins and owns byte-lane steering, extension, misalignment handling and the stall handshake.

## Interface
- MEM_DISABLE, 2'b00, op code: no access
- MEM_READ_SEXT, 2'b01, op code: load, sign-extend
- MEM_READ_ZEXT, 2'b10, op code: load, zero-extend
- MEM_WRITE, 2'b11, op code: store

Ports:
- clk  in  1  single clock; all state on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_op  in  2  one of the MEM_* codes
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or reserved-size request, no RAM write performed
- ram_addrB  out  32  byte address to RAM, bits [1:0] always 00
- ram_web  out  4  byte write enables; 0000 = read cycle
- ram_dinB  out  32  lane-steered write data
- ram_doutB  in  32  RAM read data, valid one cycle after a read cycle
- ram_readValidB  in  1  RAM read-data qualifier (registered web==0)
- ram_NOTready  in  1  RAM busy; holds the LSU

## Operation
- Little-endian; lane i = bits [8i+7:8i], ram_web[i] enables lane i. off = req_addr[1:0]; mask = 0001/0011/1111 for byte/half/word.
- States: IDLE, RD_LO, RD_HI, WR_HI.
- req_ready = (state==IDLE) && !ram_NOTready && !reset. req_op==MEM_DISABLE: accepted, no RAM activity, no response.
- Accept cycle drives RAM combinationally from the request: ram_addrB = {req_addr[31:2],2'b00}; store: ram_web = (mask<<off)[3:0], ram_dinB = req_wdata<<(8*off); load: ram_web = 0000.
- Aligned store: IDLE->IDLE; response next cycle.
- Aligned load: IDLE->RD_LO; in RD_LO capture ram_doutB when ram_readValidB && !ram_NOTready, select bytes starting at lane off, extend per op, respond, ->IDLE. Otherwise stay in RD_LO, re-driving the same address with web 0000.
- ram_readValidB is ignored outside RD_LO/RD_HI (RAM asserts it on every idle cycle).
- Outside the accept cycle and split-second-cycles: ram_web = 0000, ram_addrB/ram_dinB hold last value.
- Reserved size: error response, no RAM write, independent of configuration.
- Extension: byte -> 8 to 32, half -> 16 to 32; SEXT replicates msb, ZEXT zero-fills; word unchanged.

## Timing
- Accept at cycle N. Aligned load: RAM read at N, data at N+1, resp_valid at N+2 (registered).
- Aligned store: RAM write at N, resp_valid at N+1.
- Error: no write, resp_valid/resp_err at N+1.
- resp_valid is high exactly one cycle; resp_rdata/resp_err stable while resp_valid is high and hold afterward.
- Split cases (see Configuration): load resp_valid at N+3, store resp_valid at N+2.
- ram_NOTready high stretches RD_LO/RD_HI/WR_HI one cycle per asserted cycle; WR_HI re-drives its write until NOTready is low.
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, ram_web 0000, ram_addrB 0, ram_dinB 0. Reset mid-operation abandons it with no response; a pending WR_HI half is not written.
- Back-to-back: a new request is accepted in the cycle resp_valid is asserted for a store or error (state is IDLE).

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: accesses with all bytes in one word (e.g. half at off 1) complete as single accesses. Word-crossing accesses (half at off 3, word at off != 0) split into two.
  - Load: read lo word at N (->RD_LO), capture lo and read addr+4 at N+1 (->RD_HI), capture hi at N+2, merge, respond at N+3.
  - Store: lo write at N with web (mask<<off)[3:0], WR_HI write at N+1 to addr+4 with web (mask<<off)[7:4] and data req_wdata>>(8*(4-off)); respond at N+2.
  - 0xFFFFFFFC+4 wraps to 0.
- Not defined: any naturally misaligned access (half addr[0]=1, word addr[1:0]!=0) produces an error response at N+1 with no RAM write; RD_HI/WR_HI unreachable.

## Test plan
- SEXT byte load, addr 0x103, RAM word 0x80FF_1234 -> ram_web 0000 at N, resp_rdata 0xFFFF_FF80 at N+2.
- ZEXT half load, addr 0x202, word 0xBEEF_0000 -> 0x0000_BEEF; SEXT -> 0xFFFF_BEEF.
- Byte store 0xAB at addr 0x301 -> ram_web 0010, ram_dinB[15:8]=0xAB at N, resp_valid at N+1, resp_err 0.
- Word load at addr 0x402: SPLIT_EN, lo 0x3322_1100, hi 0x7766_5544 -> 0x5544_3322 at N+3; without macro -> resp_err 1 at N+1, no RAM write.
- Word store 0xDDCC_BBAA at addr 0x503 with SPLIT_EN, reset asserted at N+1 -> only lane 3 of 0x500 written (0xAA), no resp_valid, state IDLE.
- ram_NOTready high for 2 cycles during RD_LO -> req_ready low, address held, resp_valid delayed 2 cycles, data correct.
